// File: rtl/p256_sqr_chain.sv
// ----------------------------------------------------------------------------
// p256_sqr_chain
//
// Sequencer that runs an external P-256 modular squaring core k times back to
// back, producing x^(2^k) mod P. Two 8x32 operand banks are ping-ponged: the
// core reads its operand from bank[sel] and writes its result to bank[~sel].
// After each squaring, sel flips so the new result becomes the next operand.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, count_i      begin a chain of count_i squarings (sampled in IDLE)
//   busy_o, done_o        chain in progress / one-cycle completion pulse
//   ld_wren_i/addr/data   host operand load into bank[sel] (IDLE only)
//   rd_addr_i, rd_data_o  combinational readback of bank[sel]
//   sq_ena_o, sq_rdy_i    registered enable / completion flag to the core
//   sq_a_addr_i,
//   sq_a_din_o            core operand read port, 1-cycle registered latency
//   sq_d_addr_i,
//   sq_d_wren_i,
//   sq_d_dout_i           core result write port into bank[~sel] (RUN only)
// ----------------------------------------------------------------------------
module p256_sqr_chain #(
   parameter int COUNT_W = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [COUNT_W-1:0] count_i,
   output logic               busy_o,
   output logic               done_o,
   input  logic               ld_wren_i,
   input  logic [2:0]         ld_addr_i,
   input  logic [31:0]        ld_data_i,
   input  logic [2:0]         rd_addr_i,
   output logic [31:0]        rd_data_o,
   output logic               sq_ena_o,
   input  logic               sq_rdy_i,
   input  logic [2:0]         sq_a_addr_i,
   output logic [31:0]        sq_a_din_o,
   input  logic [2:0]         sq_d_addr_i,
   input  logic               sq_d_wren_i,
   input  logic [31:0]        sq_d_dout_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_SWAP = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic               sel_q,   sel_d;
   logic [COUNT_W-1:0] rem_q,   rem_d;
   logic               ena_q,   ena_d;
   logic [31:0]        a_din_q;

   // Operand banks; contents deliberately have no reset.
   logic [31:0]        bank_q [2][8];

   // -------------------------------------------------------------------------
   // State register (plus the control registers that move with it)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         sel_q   <= 1'b0;
         rem_q   <= '0;
         ena_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
         ena_q   <= ena_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rem_d   = rem_q;
      ena_d   = ena_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (count_i == '0) begin
                  // Zero-length chain: operand already is the result.
                  state_d = S_DONE;
               end else begin
                  rem_d   = count_i;
                  ena_d   = 1'b1;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (sq_rdy_i) begin
               ena_d   = 1'b0;
               state_d = S_SWAP;
            end
         end
         S_SWAP: begin
            sel_d = ~sel_q;
            rem_d = rem_q - COUNT_W'(1);
            state_d = (rem_q == COUNT_W'(1)) ? S_DONE : S_GAP;
         end
         S_GAP: begin
            // Wait out any rdy still held from the previous squaring so it is
            // not mistaken for completion of the next one.
            if (!sq_rdy_i) begin
               ena_d   = 1'b1;
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            ena_d   = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      busy_o = (state_q == S_RUN) || (state_q == S_SWAP) || (state_q == S_GAP);
      done_o = (state_q == S_DONE);
   end

   assign sq_ena_o   = ena_q;
   assign sq_a_din_o = a_din_q;
   assign rd_data_o  = bank_q[sel_q][rd_addr_i];

   // -------------------------------------------------------------------------
   // Bank writes. Host loads (IDLE) and core writes (RUN) occupy disjoint
   // states, so a single priority chain never drops a legal write.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (ld_wren_i && (state_q == S_IDLE)) begin
         bank_q[sel_q][ld_addr_i] <= ld_data_i;
      end else if (sq_d_wren_i && (state_q == S_RUN)) begin
         bank_q[~sel_q][sq_d_addr_i] <= sq_d_dout_i;
      end
   end

   // Core operand port behaves like a synchronous RAM read of the source bank.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_din_q <= '0;
      end else begin
         a_din_q <= bank_q[sel_q][sq_a_addr_i];
      end
   end

endmodule

// File: tb/tb_p256_sqr_chain.sv
module tb_p256_sqr_chain;

   localparam logic [255:0] P256 =
      256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
   localparam logic [255:0] GX =
      256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
   localparam logic [255:0] R256 =
      256'h00000000fffffffeffffffffffffffffffffffff000000000000000000000001;

   logic        clk = 1'b0;
   logic        rst_i, start_i, ld_wren_i;
   logic [7:0]  count_i;
   logic [2:0]  ld_addr_i, rd_addr_i, sq_a_addr_i, sq_d_addr_i;
   logic [31:0] ld_data_i, rd_data_o, sq_a_din_o, sq_d_dout_i;
   logic        busy_o, done_o, sq_ena_o, sq_rdy_i, sq_d_wren_i;

   int tests = 0;
   int errors = 0;

   always #5 clk = ~clk;

   p256_sqr_chain #(.COUNT_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .count_i     (count_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ld_wren_i   (ld_wren_i),
      .ld_addr_i   (ld_addr_i),
      .ld_data_i   (ld_data_i),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .sq_ena_o    (sq_ena_o),
      .sq_rdy_i    (sq_rdy_i),
      .sq_a_addr_i (sq_a_addr_i),
      .sq_a_din_o  (sq_a_din_o),
      .sq_d_addr_i (sq_d_addr_i),
      .sq_d_wren_i (sq_d_wren_i),
      .sq_d_dout_i (sq_d_dout_i)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] sqr_mod(input logic [255:0] a);
      logic [511:0] p;
      p = {256'd0, a} * {256'd0, a};
      return 256'(p % {256'd0, P256});
   endfunction

   // ---------------- monitor: ena rises, done pulses, GAP discipline -------
   int   ena_rises = 0;
   int   done_cnt  = 0;
   int   gap_viol  = 0;
   logic ena_prev  = 1'b0;
   logic rdy_prev  = 1'b0;

   always @(negedge clk) begin
      if (sq_ena_o && !ena_prev) begin
         ena_rises++;
         if (rdy_prev) gap_viol++;
      end
      if (done_o) done_cnt++;
      ena_prev = sq_ena_o;
      rdy_prev = sq_rdy_i;
   end

   // ---------------- squaring core model -----------------------------------
   logic core_busy  = 1'b0;
   int   core_extra = 0;

   initial begin : core
      logic [255:0] op, res;
      sq_rdy_i = 0; sq_a_addr_i = 0; sq_d_addr_i = 0; sq_d_wren_i = 0; sq_d_dout_i = 0;
      forever begin
         @(posedge clk); #1;
         if (sq_ena_o && !sq_rdy_i) begin
            core_busy = 1'b1;
            for (int i = 0; i < 8; i++) begin
               sq_a_addr_i = 3'(i);
               @(posedge clk); #1;
               op[i*32 +: 32] = sq_a_din_o;
            end
            res = sqr_mod(op);
            for (int i = 0; i < 8; i++) begin
               sq_d_addr_i = 3'(i);
               sq_d_dout_i = res[i*32 +: 32];
               sq_d_wren_i = 1'b1;
               @(posedge clk); #1;
            end
            sq_d_wren_i = 1'b0;
            sq_rdy_i    = 1'b1;
            for (int n = 0; n < 100 && sq_ena_o; n++) begin
               @(posedge clk); #1;
            end
            repeat (core_extra) begin
               @(posedge clk); #1;
            end
            sq_rdy_i  = 1'b0;
            core_busy = 1'b0;
         end
      end
   end

   // ---------------- host tasks --------------------------------------------
   task automatic load(input logic [255:0] v);
      for (int i = 0; i < 8; i++) begin
         ld_addr_i = 3'(i);
         ld_data_i = v[i*32 +: 32];
         ld_wren_i = 1'b1;
         @(posedge clk); #1;
      end
      ld_wren_i = 1'b0;
   endtask

   task automatic readback(output logic [255:0] v);
      for (int i = 0; i < 8; i++) begin
         rd_addr_i = 3'(i);
         #1;
         v[i*32 +: 32] = rd_data_o;
      end
   endtask

   task automatic start_chain(input logic [7:0] k);
      count_i = k;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 256'(done_o), 256'd1);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 256'(done_o), 256'd0);
   endtask

   // ---------------- main sequence -----------------------------------------
   initial begin : main
      logic [255:0] v;
      int r0, r1, d0, n;
      rst_i = 1'b1; start_i = 0; count_i = 0;
      ld_wren_i = 0; ld_addr_i = 0; ld_data_i = 0; rd_addr_i = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  256'(busy_o),     256'd0);
      chk("rst_done",  256'(done_o),     256'd0);
      chk("rst_ena",   256'(sq_ena_o),   256'd0);
      chk("rst_a_din", 256'(sq_a_din_o), 256'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      // 2^(2^3) = 0x100
      load(256'd2);
      r0 = ena_rises;
      start_chain(8'd3);
      @(negedge clk);
      chk("t1_busy", 256'(busy_o),   256'd1);
      chk("t1_ena",  256'(sq_ena_o), 256'd1);
      wait_done("t1_done");
      chk("t1_rises", 256'(ena_rises - r0), 256'd3);
      readback(v);
      chk("t1_result", v, 256'h100);

      // (2^16)^(2^4) = 2^256 mod P
      load(256'h10000);
      r0 = ena_rises;
      start_chain(8'd4);
      wait_done("t2_done");
      chk("t2_rises", 256'(ena_rises - r0), 256'd4);
      readback(v);
      chk("t2_result", v, R256);

      // Gx^2 mod P
      load(GX);
      r0 = ena_rises;
      start_chain(8'd1);
      wait_done("t3_done");
      chk("t3_rises", 256'(ena_rises - r0), 256'd1);
      readback(v);
      chk("t3_result", v, sqr_mod(GX));

      // count==0: immediate done, no core activity, operand unchanged
      load(256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0);
      r0 = ena_rises;
      d0 = done_cnt;
      start_chain(8'd0);
      @(negedge clk);
      chk("t0_done", 256'(done_o), 256'd1);
      chk("t0_busy", 256'(busy_o), 256'd0);
      @(posedge clk); #1;
      chk("t0_pulse", 256'(done_o), 256'd0);
      repeat (3) @(posedge clk); #1;
      chk("t0_rises", 256'(ena_rises - r0), 256'd0);
      chk("t0_dones", 256'(done_cnt - d0), 256'd1);
      readback(v);
      chk("t0_result", v,
          256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0);

      // Sticky rdy core, plus start / ld_wren mid-chain: 3^4 = 81
      core_extra = 3;
      load(256'd3);
      r0 = ena_rises;
      n  = gap_viol;
      start_chain(8'd2);
      repeat (4) @(posedge clk); #1;
      start_i = 1'b1; count_i = 8'd0;
      ld_wren_i = 1'b1; ld_addr_i = 3'd0; ld_data_i = 32'hdeadbeef;
      @(posedge clk); #1;
      start_i = 1'b0; ld_wren_i = 1'b0;
      wait_done("t4_done");
      chk("t4_rises", 256'(ena_rises - r0), 256'd2);
      chk("t4_gap",   256'(gap_viol - n),    256'd0);
      readback(v);
      chk("t4_result", v, 256'd81);
      core_extra = 0;

      // Reset during the second squaring of a count=5 chain
      load(256'd2);
      r0 = ena_rises;
      start_chain(8'd5);
      n = 0;
      while (ena_rises < r0 + 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_second_sq", 256'(ena_rises - r0), 256'd2);
      repeat (3) @(posedge clk); #1;
      d0 = done_cnt;
      rst_i = 1'b1;
      @(negedge clk);
      chk("t5_rst_ena",  256'(sq_ena_o), 256'd0);
      chk("t5_rst_busy", 256'(busy_o),   256'd0);
      repeat (2) @(posedge clk); #1;
      rst_i = 1'b0;
      r1 = ena_rises;
      n = 0;
      while (core_busy && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_core_idle", 256'(core_busy), 256'd0);
      repeat (5) @(posedge clk); #1;
      chk("t5_no_done", 256'(done_cnt - d0),  256'd0);
      chk("t5_no_ena",  256'(ena_rises - r1), 256'd0);

      // Fresh chain after reset: 5^4 = 625
      load(256'd5);
      r0 = ena_rises;
      start_chain(8'd2);
      wait_done("t6_done");
      chk("t6_rises", 256'(ena_rises - r0), 256'd2);
      readback(v);
      chk("t6_result", v, 256'd625);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/p256_sqr_chain.md
# p256_sqr_chain

Sequencer that drives the P-256 modular squaring core through a chain of k back-to-back squarings, computing x^(2^k) mod P. It sits between the host/register side and one squaring core. It owns two 8x32 operand banks and ping-pongs between them: the core reads the operand from one bank and writes its result into the other, then the roles swap. The block is the building block for the exponentiation ladders used in field inversion and square roots.

## Interface
- COUNT_W, 8, width of the squaring-count input; chains of 0..2^COUNT_W-1 squarings.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a chain; sampled only in IDLE.
- count  in  COUNT_W  number of squarings k; sampled with start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when the result is readable.
- ld_wren  in  1  write operand word into the current bank; ignored unless IDLE.
- ld_addr  in  3  operand word index; 0 is the least-significant word.
- ld_data  in  32  operand word.
- rd_addr  in  3  result word index.
- rd_data  out  32  combinational read of the current bank at rd_addr.
- sq_ena  out  1  enable to the squaring core; registered.
- sq_rdy  in  1  core completion flag.
- sq_a_addr  in  3  core operand read address.
- sq_a_din  out  32  operand word; registered read of the source bank at sq_a_addr, 1-cycle latency, like a synchronous RAM.
- sq_d_addr  in  3  core result write address.
- sq_d_wren  in  1  core result write strobe.
- sq_d_dout  in  32  core result word.

## Operation
- Banks: bank[0] and bank[1], 8x32 each. The 1-bit register sel selects the current (source) bank; the destination bank is bank[~sel].
  - ld_wren and rd_data use bank[sel].
  - sq_d_wren writes bank[~sel][sq_d_addr], and only while in RUN. Core writes in any other state are dropped.
- Bank contents are not reset.
- Remaining counter rem is COUNT_W bits.
- States:
  - IDLE: if start and count==0, go to DONE with banks and sel unchanged. If start and count!=0, set rem<=count and sq_ena<=1, and go to RUN.
  - RUN: hold sq_ena=1. When sq_rdy==1 is sampled, set sq_ena<=0 and go to SWAP.
  - SWAP: set sel<=~sel and rem<=rem-1. If rem==1, go to DONE; otherwise go to GAP.
  - GAP: hold sq_ena=0. Stay until sq_rdy==0 is sampled, then set sq_ena<=1 and go to RUN. GAP lasts at least 1 cycle, which guarantees an ena low pulse and keeps a stale rdy from being taken as a completion.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- start while not in IDLE is ignored. ld_wren while not in IDLE is ignored.
- Reset, including mid-chain: go to IDLE with sel=0, rem=0, sq_ena=0, busy=0, done=0, sq_a_din=0. A chain in progress is abandoned and the core sees ena fall.

## Timing
- Reset values: busy=0, done=0, sq_ena=0, sq_a_din=0. rd_data reflects bank[0], whose contents are undefined.
- start accepted at edge T0: busy=1 and sq_ena=1 from T0+1.
- Per squaring: L_core cycles in RUN (from sq_ena rise to sampled sq_rdy), plus 1 SWAP cycle, plus at least 1 GAP cycle (none after the final squaring).
- done is high in the cycle after the final SWAP. rd_data is valid with the new sel in that same cycle.
- count==0: done is high at T0+1. busy stays 0 throughout.
- sq_a_din is updated every cycle from bank[sel][sq_a_addr] regardless of state.
- A core write and an ld_wren cannot collide: they are legal in disjoint states.

## Test plan
- Load 2 into word0 and 0 into words1..7, with count=3. Required: exactly 3 sq_ena rise/fall cycles, then done, then rd_data word0=0x100 and words1..7=0.
- Load 2^16 (word0=0x00010000), count=4. Required: result words7..0 = 00000000 fffffffe ffffffff ffffffff ffffffff 00000000 00000000 00000001, which is 2^256 mod P.
- Load Gx=6b17d1f2...d898c296, count=1. Required: result equals the Gx*Gx % P golden value; sel has toggled once.
- count=0 with any operand. Required: done exactly 1 cycle after start, sq_ena never rises, operand readback unchanged.
- A core model holds rdy high until ena falls, plus 3 extra cycles. Required: GAP holds sq_ena low until rdy==0, with no double-counted squaring. A start pulse and ld_wren issued mid-chain have no effect.
- Assert rst during the second squaring of a count=5 chain. Required: next cycle sq_ena=0, busy=0, done never pulses. A new start after rst with a freshly loaded operand completes correctly.
